// File: rtl/tt_um_tkm_uart_tx.sv
// rtl/tt_um_tkm_uart_tx.sv - TinyTapeout UART transmitter tile (8 data bits, optional even parity, 1 stop bit)
module tt_um_tkm_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [9:0] BAUD_MAX = 10'(CLKS_PER_BIT - 1);

  logic [2:0] state;
  logic [9:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       parity_bit;
  logic       tx_r;
  logic       ready_r;
  logic [5:0] frames_sent;
  logic       bit_done;
  logic       valid;
  logic       unused_ok;

  assign valid     = uio_in[0];
  assign unused_ok = &{1'b0, uio_in[7:1]};
  assign bit_done  = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      tx_r        <= 1'b1;
      ready_r     <= 1'b1;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_r     <= 1'b1;
          ready_r  <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (valid && ena) begin
            state      <= START;
            tx_r       <= 1'b0;
            ready_r    <= 1'b0;
            shift      <= ui_in;
            parity_bit <= ^ui_in;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx_r     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 10'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_r  <= parity_bit;
              end else begin
                state <= STOP;
                tx_r  <= 1'b1;
              end
            end else begin
              // Next data bit is shift[1] because the shift happens on this same edge.
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_r    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 10'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_r     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 10'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt    <= '0;
            state       <= IDLE;
            tx_r        <= 1'b1;
            ready_r     <= 1'b1;
            frames_sent <= frames_sent + 6'd1;
          end else begin
            baud_cnt <= baud_cnt + 10'd1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_r     <= 1'b1;
          ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign uo_out  = {frames_sent, ready_r, tx_r};
  assign uio_out = {5'b0, tx_r, ready_r, 1'b0};
  assign uio_oe  = 8'b0000_0110;

endmodule

// File: tb/tb_tt_um_tkm_uart_tx.sv
// tb/tb_tt_um_tkm_uart_tx.sv - self-checking bench for the UART transmit tile
module tb_tt_um_tkm_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui0 = 8'h00;
  logic [7:0] ui1 = 8'h00;
  logic       vin0 = 1'b0;
  logic       vin1 = 1'b0;
  logic [7:0] uo0, uio_out0, uio_oe0;
  logic [7:0] uo1, uio_out1, uio_oe1;
  logic [7:0] uio_in0, uio_in1;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  assign uio_in0 = {7'b1010101, vin0};
  assign uio_in1 = {7'b0101010, vin1};

  always #5 clk = ~clk;

  tt_um_tkm_uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui0), .uio_in(uio_in0),
    .uo_out(uo0), .uio_out(uio_out0), .uio_oe(uio_oe0)
  );

  tt_um_tkm_uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui1), .uio_in(uio_in1),
    .uo_out(uo1), .uio_out(uio_out1), .uio_oe(uio_oe1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic txv(input int sel);
    return (sel != 0) ? uo1[0] : uo0[0];
  endfunction

  function automatic logic rdy(input int sel);
    return (sel != 0) ? uo1[1] : uo0[1];
  endfunction

  task automatic mwait(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  // Decodes frames off the serial line by sampling at bit centres.
  task automatic mon_loop(input int sel);
    logic prev;
    logic cur;
    logic st, p, s;
    logic [7:0] d;
    logic [8:0] e;
    bit ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = txv(sel);
      if (prev === 1'b1 && cur === 1'b0 && rst_n === 1'b1) begin
        ab = 1'b0;
        mwait(8, ab);
        st = txv(sel);
        for (int i = 0; i < 8; i++) begin
          mwait(16, ab);
          d[i] = txv(sel);
        end
        p = 1'b0;
        if (sel != 0) begin
          mwait(16, ab);
          p = txv(sel);
        end
        mwait(16, ab);
        s = txv(sel);
        if (((sel != 0) ? q1.size() : q0.size()) == 0) begin
          chk("mon_unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = (sel != 0) ? q1.pop_front() : q0.pop_front();
          if (!ab) begin
            chk("start_bit", 32'(st), 32'd0);
            chk("data_byte", 32'(d), 32'(e[7:0]));
            if (sel != 0) chk("parity_bit", 32'(p), 32'(e[8]));
            chk("stop_bit", 32'(s), 32'd1);
          end
        end
        prev = txv(sel);
      end else begin
        prev = cur;
      end
    end
  endtask

  initial mon_loop(0);
  initial mon_loop(1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input logic [7:0] b);
    if (sel != 0) q1.push_back({^b, b});
    else q0.push_back({^b, b});
  endtask

  // Drives valid for exactly one accept edge.
  task automatic start_byte(input int sel, input logic [7:0] b);
    tick();
    if (sel != 0) begin ui1 = b; vin1 = 1'b1; end
    else begin ui0 = b; vin0 = 1'b1; end
    push(sel, b);
    @(posedge clk);
    #1;
    if (sel != 0) vin1 = 1'b0;
    else vin0 = 1'b0;
  endtask

  task automatic wait_ready(input int sel, output int cnt);
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (rdy(sel) === 1'b1) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int bad;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_uo_out", 32'(uo0), 32'h03);
    chk("reset_uio_oe", 32'(uio_oe0), 32'h06);
    chk("reset_uio_out", 32'(uio_out0), 32'h06);
    chk("reset_uo_out_par", 32'(uo1), 32'h03);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    start_byte(0, 8'hA5);
    wait_ready(0, cnt);
    chk("a5_frame_len", 32'(cnt), 32'd160);
    chk("a5_frames_sent", 32'(uo0[7:2]), 32'd1);

    start_byte(1, 8'h07);
    wait_ready(1, cnt);
    chk("par07_frame_len", 32'(cnt), 32'd176);
    start_byte(1, 8'h03);
    wait_ready(1, cnt);
    chk("par03_frame_len", 32'(cnt), 32'd176);
    chk("par_frames_sent", 32'(uo1[7:2]), 32'd2);

    // Held valid: ui_in changes mid-frame, second frame takes the new value.
    tick();
    ui0 = 8'h55;
    vin0 = 1'b1;
    push(0, 8'h55);
    push(0, 8'h00);
    @(posedge clk);
    #1;
    fork
      begin
        repeat (50) @(posedge clk);
        #1;
        ui0 = 8'h00;
      end
    join_none
    wait_ready(0, cnt);
    chk("held_first_len", 32'(cnt), 32'd160);
    chk("held_gap_tx_idle", 32'(uo0[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("held_gap_ready_drop", 32'(uo0[1]), 32'd0);
    chk("held_second_start", 32'(uo0[0]), 32'd0);
    #1;
    vin0 = 1'b0;
    wait_ready(0, cnt);
    chk("held_second_len", 32'(cnt), 32'd160);
    chk("held_frames_sent", 32'(uo0[7:2]), 32'd3);

    tick();
    ena = 1'b0;
    vin0 = 1'b1;
    ui0 = 8'hFF;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uo0[1] !== 1'b1 || uo0[0] !== 1'b1) bad++;
    end
    chk("ena_low_idle", 32'(bad), 32'd0);
    tick();
    vin0 = 1'b0;
    ena = 1'b1;

    start_byte(0, 8'h3C);
    fork
      begin
        repeat (20) @(posedge clk);
        #1;
        ena = 1'b0;
      end
    join_none
    wait_ready(0, cnt);
    chk("ena_drop_frame_len", 32'(cnt), 32'd160);
    chk("ena_drop_frames_sent", 32'(uo0[7:2]), 32'd4);
    tick();
    ena = 1'b1;

    start_byte(0, 8'h5A);
    repeat (71) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midframe_reset_uo", 32'(uo0), 32'h03);
    rst_n = 1'b1;
    repeat (150) tick();

    for (int i = 0; i < 64; i++) begin
      start_byte(0, 8'(i * 37 + 1));
      wait_ready(0, cnt);
      if (i == 62) chk("wrap_count_63", 32'(uo0[7:2]), 32'd63);
    end
    chk("wrap_count_0", 32'(uo0[7:2]), 32'd0);

    repeat (20) tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
